// File: rtl/pl_trace_buffer.sv
// Trace buffer that records fetch PC, instruction and write-back ALU result while armed,
// filtering pipeline stalls and freezing on a programmable stop address.
module pl_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop_pc_en,
    input  logic [31:0]   stop_pc,
    input  logic [31:0]   pc,
    input  logic [31:0]   inst,
    input  logic [31:0]   walu,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_walu,
    output logic [AW:0]   count,
    output logic [1:0]    state,
    output logic [15:0]   dropped
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StFrozen  = 2'b10
    } state_e;

    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic          first_flag_q;
    logic [31:0]   last_pc_q;
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q;
    logic [15:0]   dropped_q;

    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_walu [DEPTH];

    logic capturing, arm_accept, trigger, qualify, pop, push, drop;

    always_comb begin
        capturing  = (state_q == StCapture);
        arm_accept = arm && !capturing;
        trigger    = capturing && stop_pc_en && (pc == stop_pc);
        // Stall filter: only a changed PC (or the first sample after arming) is recorded.
        qualify    = capturing && (first_flag_q || (pc != last_pc_q));
        pop        = (count_q != '0) && out_ready;
        push       = qualify && ((count_q != Full) || pop);
        drop       = qualify && !push;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arm) state_d = StCapture;
            end
            StCapture: begin
                if (trigger) state_d = StFrozen;
            end
            StFrozen: begin
                if (arm) begin
                    state_d = StCapture;
                end else if (count_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        state = state_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_flag_q <= 1'b0;
            last_pc_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            dropped_q    <= '0;
        end else begin
            if (arm_accept) begin
                first_flag_q <= 1'b1;
                dropped_q    <= '0;
            end else if (drop && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
            if (qualify) begin
                first_flag_q <= 1'b0;
                last_pc_q    <= pc;
            end
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; head/tail/count define which entries are live.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_pc[tail_q]   <= pc;
            mem_inst[tail_q] <= inst;
            mem_walu[tail_q] <= walu;
        end
    end

    always_comb begin
        out_valid = (count_q != '0);
        out_pc    = mem_pc[head_q];
        out_inst  = mem_inst[head_q];
        out_walu  = mem_walu[head_q];
        count     = count_q;
        dropped   = dropped_q;
    end

endmodule

// File: tb/tb_pl_trace_buffer.sv
// Directed bench for pl_trace_buffer: capture order, stall filter, overflow, trigger, reset.
module tb_pl_trace_buffer;

    logic        clock = 1'b0;
    logic        reset, arm, stop_pc_en, out_ready;
    logic [31:0] stop_pc, pc, inst, walu;
    logic        out_valid;
    logic [31:0] out_pc, out_inst, out_walu;
    logic [4:0]  count;
    logic [1:0]  state;
    logic [15:0] dropped;

    int n_cmp = 0;
    int n_err = 0;

    pl_trace_buffer #(.DEPTH(16), .AW(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .arm        (arm),
        .stop_pc_en (stop_pc_en),
        .stop_pc    (stop_pc),
        .pc         (pc),
        .inst       (inst),
        .walu       (walu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_walu   (out_walu),
        .count      (count),
        .state      (state),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc   = p;
        inst = p ^ 32'hA5A5_0000;
        walu = p + 32'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop_pc_en = 1'b0; stop_pc = '0; out_ready = 1'b0;
        set_pc(32'h0);
        step();
        step();
        reset = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);

        // Basic capture with immediate consumption
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_state", 32'(state), 32'd1);
        out_ready = 1'b1;
        set_pc(32'h0);
        step();
        check("b0_valid", 32'(out_valid), 32'd1);
        check("b0_pc", out_pc, 32'h0);
        check("b0_count", 32'(count), 32'd1);
        set_pc(32'h4);
        step();
        check("b1_pc", out_pc, 32'h4);
        check("b1_inst", out_inst, 32'hA5A5_0004);
        check("b1_walu", out_walu, 32'h5);
        check("b1_count", 32'(count), 32'd1);
        set_pc(32'h8);
        step();
        check("b2_pc", out_pc, 32'h8);
        check("b2_count", 32'(count), 32'd1);
        step();
        check("b_drained", 32'(count), 32'd0);

        // Stall filter
        out_ready = 1'b0;
        set_pc(32'h10);
        repeat (4) step();
        check("stall_count", 32'(count), 32'd1);
        set_pc(32'h14);
        step();
        check("stall_count2", 32'(count), 32'd2);
        check("stall_head", out_pc, 32'h10);
        check("stall_dropped", 32'(dropped), 32'd0);
        out_ready = 1'b1;
        step();
        check("stall_next", out_pc, 32'h14);
        step();
        check("stall_empty", 32'(out_valid), 32'd0);

        // Overflow: 20 distinct PCs into a 16-entry FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_pc(32'h100 + 32'(4 * i));
            step();
        end
        check("full_count", 32'(count), 32'd16);
        check("full_dropped", 32'(dropped), 32'd4);
        check("full_head", out_pc, 32'h100);

        // Push and pop at the same edge while full
        out_ready = 1'b1;
        set_pc(32'h200);
        step();
        check("pp_count", 32'(count), 32'd16);
        check("pp_dropped", 32'(dropped), 32'd4);
        check("pp_head", out_pc, 32'h104);

        // Trigger on a full-with-pop cycle, then drain in FROZEN
        stop_pc_en = 1'b1;
        stop_pc = 32'h204;
        set_pc(32'h204);
        step();
        stop_pc_en = 1'b0;
        check("trig_state", 32'(state), 32'd2);
        check("trig_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_pc;
            exp_pc = (i < 14) ? 32'h108 + 32'(4 * i) : ((i == 14) ? 32'h200 : 32'h204);
            check($sformatf("drain%0d", i), out_pc, exp_pc);
            step();
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_still_frozen", 32'(state), 32'd2);
        step();
        check("drain_idle", 32'(state), 32'd0);

        // Stop-address trigger sequence
        arm = 1'b1;
        out_ready = 1'b0;
        step();
        arm = 1'b0;
        check("rearm_dropped", 32'(dropped), 32'd0);
        stop_pc_en = 1'b1;
        stop_pc = 32'h20;
        set_pc(32'h18); step();
        set_pc(32'h1C); step();
        set_pc(32'h20); step();
        check("stop_state", 32'(state), 32'd2);
        check("stop_count", 32'(count), 32'd3);
        set_pc(32'h24); step();
        check("stop_count_after", 32'(count), 32'd3);
        out_ready = 1'b1;
        check("stop_e0", out_pc, 32'h18); step();
        check("stop_e1", out_pc, 32'h1C); step();
        check("stop_e2", out_pc, 32'h20); step();
        check("stop_empty", 32'(count), 32'd0);
        step();
        check("stop_idle", 32'(state), 32'd0);

        // Re-arm: first sample captured even when pc equals last captured pc
        stop_pc_en = 1'b0;
        out_ready = 1'b0;
        set_pc(32'h20);
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("first_count", 32'(count), 32'd1);
        check("first_pc", out_pc, 32'h20);
        step();
        check("first_stall", 32'(count), 32'd1);

        // Reset mid-capture with 5 entries stored
        for (int i = 0; i < 4; i++) begin
            set_pc(32'h30 + 32'(4 * i));
            step();
        end
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_state", 32'(state), 32'd1);
        reset = 1'b1;
        arm = 1'b1;
        step();
        reset = 1'b0;
        arm = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_dropped", 32'(dropped), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
